// File: rtl/mul_stage.sv
// Mantissa-multiply stage of the FP MAC: two-register pipeline that turns four
// unpacked operand pairs into raw sign / exponent-sum / mantissa-product / zero.
module mul_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_op,
    input  logic        x0_s, x1_s, x2_s, x3_s,
    input  logic        y0_s, y1_s, y2_s, y3_s,
    input  logic [7:0]  x0_e, x1_e, x2_e, x3_e,
    input  logic [7:0]  y0_e, y1_e, y2_e, y3_e,
    input  logic [11:0] x0_H, x1_H, x2_H, x3_H,
    input  logic [11:0] x0_L, x1_L, x2_L, x3_L,
    input  logic [11:0] y0_H, y1_H, y2_H, y3_H,
    input  logic [11:0] y0_L, y1_L, y2_L, y3_L,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_op,
    output logic        p0_s, p1_s, p2_s, p3_s,
    output logic [9:0]  p0_e, p1_e, p2_e, p3_e,
    output logic [47:0] p0_m, p1_m, p2_m, p3_m,
    output logic        p0_z, p1_z, p2_z, p3_z
);

    logic [3:0]  w_xs, w_ys;
    logic [7:0]  w_xe [0:3];
    logic [7:0]  w_ye [0:3];
    logic [11:0] w_xh [0:3];
    logic [11:0] w_xl [0:3];
    logic [11:0] w_yh [0:3];
    logic [11:0] w_yl [0:3];

    assign w_xs = {x3_s, x2_s, x1_s, x0_s};
    assign w_ys = {y3_s, y2_s, y1_s, y0_s};
    assign w_xe[0] = x0_e;  assign w_xe[1] = x1_e;  assign w_xe[2] = x2_e;  assign w_xe[3] = x3_e;
    assign w_ye[0] = y0_e;  assign w_ye[1] = y1_e;  assign w_ye[2] = y2_e;  assign w_ye[3] = y3_e;
    assign w_xh[0] = x0_H;  assign w_xh[1] = x1_H;  assign w_xh[2] = x2_H;  assign w_xh[3] = x3_H;
    assign w_xl[0] = x0_L;  assign w_xl[1] = x1_L;  assign w_xl[2] = x2_L;  assign w_xl[3] = x3_L;
    assign w_yh[0] = y0_H;  assign w_yh[1] = y1_H;  assign w_yh[2] = y2_H;  assign w_yh[3] = y3_H;
    assign w_yl[0] = y0_L;  assign w_yl[1] = y1_L;  assign w_yl[2] = y2_L;  assign w_yl[3] = y3_L;

    logic        r_s1_valid, r_s1_op;
    logic [3:0]  r_s1_s, r_s1_z;
    logic [9:0]  r_s1_e  [0:3];
    logic [23:0] r_s1_ll [0:3];
    logic [23:0] r_s1_lh [0:3];
    logic [23:0] r_s1_hl [0:3];
    logic [23:0] r_s1_hh [0:3];

    logic        r_s2_valid, r_s2_op;
    logic [3:0]  r_s2_s, r_s2_z;
    logic [9:0]  r_s2_e [0:3];
    logic [47:0] r_s2_m [0:3];

    logic        w_s2_load, w_s1_load;
    logic [9:0]  w_bias;
    logic [9:0]  w_e1 [0:3];
    logic [9:0]  w_e2 [0:3];
    logic [47:0] w_m2 [0:3];

    // S2 frees up whenever it is empty or being drained; S1 follows S2.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    assign w_bias = in_op ? 10'd127 : 10'd15;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_e1[i] = {2'b00, w_xe[i]} + {2'b00, w_ye[i]} - w_bias;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_m2[i] = 48'd0;
            w_e2[i] = 10'd0;
            if (!r_s1_z[i]) begin
                w_e2[i] = r_s1_e[i];
                if (r_s1_op) begin
                    w_m2[i] = {r_s1_hh[i], 24'd0}
                            + {11'd0, ({1'b0, r_s1_lh[i]} + {1'b0, r_s1_hl[i]}), 12'd0}
                            + {24'd0, r_s1_ll[i]};
                end else begin
                    w_m2[i] = {26'd0, r_s1_ll[i][21:0]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 1'b0;
            r_s1_s     <= 4'd0;
            r_s1_z     <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_s1_e[i]  <= 10'd0;
                r_s1_ll[i] <= 24'd0;
                r_s1_lh[i] <= 24'd0;
                r_s1_hl[i] <= 24'd0;
                r_s1_hh[i] <= 24'd0;
            end
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_op <= in_op;
                r_s1_s  <= w_xs ^ w_ys;
                for (int i = 0; i < 4; i++) begin
                    r_s1_z[i]  <= (w_xe[i] == 8'd0) || (w_ye[i] == 8'd0);
                    r_s1_e[i]  <= w_e1[i];
                    r_s1_ll[i] <= {12'd0, w_xl[i]} * {12'd0, w_yl[i]};
                    r_s1_lh[i] <= {12'd0, w_xl[i]} * {12'd0, w_yh[i]};
                    r_s1_hl[i] <= {12'd0, w_xh[i]} * {12'd0, w_yl[i]};
                    r_s1_hh[i] <= {12'd0, w_xh[i]} * {12'd0, w_yh[i]};
                end
            end
        end
    end

    // Data is only rewritten when a real bundle moves in, so held outputs stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_op    <= 1'b0;
            r_s2_s     <= 4'd0;
            r_s2_z     <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_s2_e[i] <= 10'd0;
                r_s2_m[i] <= 48'd0;
            end
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_op <= r_s1_op;
                r_s2_s  <= r_s1_s;
                r_s2_z  <= r_s1_z;
                for (int i = 0; i < 4; i++) begin
                    r_s2_e[i] <= w_e2[i];
                    r_s2_m[i] <= w_m2[i];
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_op    = r_s2_op;
    assign {p3_s, p2_s, p1_s, p0_s} = r_s2_s;
    assign {p3_z, p2_z, p1_z, p0_z} = r_s2_z;
    assign p0_e = r_s2_e[0];
    assign p1_e = r_s2_e[1];
    assign p2_e = r_s2_e[2];
    assign p3_e = r_s2_e[3];
    assign p0_m = r_s2_m[0];
    assign p1_m = r_s2_m[1];
    assign p2_m = r_s2_m[2];
    assign p3_m = r_s2_m[3];

endmodule

// File: tb/tb_mul_stage.sv
// Scoreboard bench for mul_stage: directed cases, backpressure, reset and a
// random mixed-op stream checked against a plain-arithmetic product model.
module tb_mul_stage;

    typedef struct packed {
        logic             op;
        logic [3:0]       s;
        logic [3:0]       z;
        logic [3:0][9:0]  e;
        logic [3:0][47:0] m;
    } bundle_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_op, out_valid, out_ready, out_op;
    logic [3:0]        xs, ys;
    logic [3:0][7:0]   xe, ye;
    logic [3:0][11:0]  xh, xl, yh, yl;
    logic p0_s, p1_s, p2_s, p3_s, p0_z, p1_z, p2_z, p3_z;
    logic [9:0]  p0_e, p1_e, p2_e, p3_e;
    logic [47:0] p0_m, p1_m, p2_m, p3_m;

    int checks = 0;
    int errors = 0;
    bundle_t q[$];
    logic accepted = 1'b0;

    always #5 clk = ~clk;

    mul_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .x0_s(xs[0]), .x1_s(xs[1]), .x2_s(xs[2]), .x3_s(xs[3]),
        .y0_s(ys[0]), .y1_s(ys[1]), .y2_s(ys[2]), .y3_s(ys[3]),
        .x0_e(xe[0]), .x1_e(xe[1]), .x2_e(xe[2]), .x3_e(xe[3]),
        .y0_e(ye[0]), .y1_e(ye[1]), .y2_e(ye[2]), .y3_e(ye[3]),
        .x0_H(xh[0]), .x1_H(xh[1]), .x2_H(xh[2]), .x3_H(xh[3]),
        .x0_L(xl[0]), .x1_L(xl[1]), .x2_L(xl[2]), .x3_L(xl[3]),
        .y0_H(yh[0]), .y1_H(yh[1]), .y2_H(yh[2]), .y3_H(yh[3]),
        .y0_L(yl[0]), .y1_L(yl[1]), .y2_L(yl[2]), .y3_L(yl[3]),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .p0_s(p0_s), .p1_s(p1_s), .p2_s(p2_s), .p3_s(p3_s),
        .p0_e(p0_e), .p1_e(p1_e), .p2_e(p2_e), .p3_e(p3_e),
        .p0_m(p0_m), .p1_m(p1_m), .p2_m(p2_m), .p3_m(p3_m),
        .p0_z(p0_z), .p1_z(p1_z), .p2_z(p2_z), .p3_z(p3_z)
    );

    // Reference: whole-mantissa product and integer exponent arithmetic.
    function automatic bundle_t model();
        bundle_t r;
        longint unsigned ma, mb, prod;
        int ex;
        r = '0;
        r.op = in_op;
        for (int i = 0; i < 4; i++) begin
            r.s[i] = xs[i] ^ ys[i];
            r.z[i] = (xe[i] == 0) || (ye[i] == 0);
            if (!r.z[i]) begin
                ex = int'(xe[i]) + int'(ye[i]) - (in_op ? 127 : 15);
                r.e[i] = ex[9:0];
                if (in_op) begin
                    ma = xh[i]; ma = ma * 4096 + xl[i];
                    mb = yh[i]; mb = mb * 4096 + yl[i];
                    prod = ma * mb;
                end else begin
                    ma = xl[i];
                    mb = yl[i];
                    prod = (ma * mb) % 64'd4194304;
                end
                r.m[i] = prod[47:0];
            end
        end
        return r;
    endfunction

    function automatic bundle_t get_out();
        bundle_t b;
        b.op = out_op;
        b.s  = {p3_s, p2_s, p1_s, p0_s};
        b.z  = {p3_z, p2_z, p1_z, p0_z};
        b.e  = {p3_e, p2_e, p1_e, p0_e};
        b.m  = {p3_m, p2_m, p1_m, p0_m};
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input bundle_t act, input bundle_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic rand_inputs(input logic op);
        in_op = op;
        for (int i = 0; i < 4; i++) begin
            xs[i] = 1'($urandom_range(0, 1));
            ys[i] = 1'($urandom_range(0, 1));
            xe[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : (op ? 8'($urandom_range(1, 255)) : 8'($urandom_range(1, 31)));
            ye[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : (op ? 8'($urandom_range(1, 255)) : 8'($urandom_range(1, 31)));
            xh[i] = 12'($urandom_range(0, 4095));
            xl[i] = 12'($urandom_range(0, 4095));
            yh[i] = 12'($urandom_range(0, 4095));
            yl[i] = 12'($urandom_range(0, 4095));
        end
    endtask

    // One clock: note acceptance mid-cycle, then land just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        accepted = in_valid && in_ready && !rst;
        if (accepted) q.push_back(model());
        @(posedge clk);
        #1;
    endtask

    // Present the current inputs once, then expect out_valid exactly two edges later.
    task automatic send_and_wait(input string name);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk({name, "_accept"}, 64'(accepted), 64'd1);
        in_valid = 1'b0;
        chk({name, "_lat1"}, 64'(out_valid), 64'd0);
        cycle();
        chk({name, "_lat2"}, 64'(out_valid), 64'd1);
    endtask

    // Monitor: pops on every output transfer and checks stability while stalled.
    initial begin
        bundle_t cur, prev, exp;
        logic have_prev;
        have_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 1'b0;
            end else begin
                cur = get_out();
                if (have_prev && out_valid) chk_b("stall_hold", cur, prev);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=%h required=none", cur);
                    end else begin
                        exp = q.pop_front();
                        chk_b("scoreboard", cur, exp);
                    end
                end
                have_prev = out_valid && !out_ready;
                prev = cur;
            end
        end
    end

    initial begin
        int n_acc, sent, guard;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        rand_inputs(1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk_b("reset_outputs", get_out(), bundle_t'(0));
        rst = 1'b0;

        // 1.5 x 2.0 single precision on lane 0
        rand_inputs(1'b1);
        xs[0] = 1'b0; xe[0] = 8'd127; xh[0] = 12'hC00; xl[0] = 12'h000;
        ys[0] = 1'b0; ye[0] = 8'd128; yh[0] = 12'h800; yl[0] = 12'h000;
        send_and_wait("sp_mul");
        chk("sp_p0_s", 64'(p0_s), 64'd0);
        chk("sp_p0_e", 64'(p0_e), 64'd128);
        chk("sp_p0_m", 64'(p0_m), 64'h6000_0000_0000);
        chk("sp_p0_z", 64'(p0_z), 64'd0);
        cycle();

        // 1.0 x -2.0 half precision on lane 1
        rand_inputs(1'b0);
        xs[1] = 1'b0; xe[1] = 8'd15; xl[1] = 12'h400;
        ys[1] = 1'b1; ye[1] = 8'd16; yl[1] = 12'h400;
        send_and_wait("hp_mul");
        chk("hp_p1_s", 64'(p1_s), 64'd1);
        chk("hp_p1_e", 64'(p1_e), 64'd16);
        chk("hp_p1_m", 64'(p1_m), 64'h10_0000);
        chk("hp_out_op", 64'(out_op), 64'd0);
        cycle();

        // zero operand on lane 2, large exponents on lane 3
        rand_inputs(1'b1);
        xs[2] = 1'b0; xe[2] = 8'd0; ys[2] = 1'b1; ye[2] = 8'd77;
        xe[3] = 8'd254; ye[3] = 8'd254;
        send_and_wait("zero_big");
        chk("zero_p2_z", 64'(p2_z), 64'd1);
        chk("zero_p2_m", 64'(p2_m), 64'd0);
        chk("zero_p2_e", 64'(p2_e), 64'd0);
        chk("zero_p2_s", 64'(p2_s), 64'd1);
        chk("big_p3_e", 64'(p3_e), 64'd381);
        cycle();

        rand_inputs(1'b1);
        xe[3] = 8'd1; ye[3] = 8'd1;
        send_and_wait("small_exp");
        chk("small_p3_e", 64'(p3_e), 64'h383);
        cycle();

        // backpressure: five back-to-back bundles, out_ready low for four cycles
        out_ready = 1'b0; n_acc = 0;
        rand_inputs(1'($urandom_range(0, 1)));
        in_valid = 1'b1;
        repeat (4) begin
            cycle();
            if (accepted) begin
                n_acc++;
                if (n_acc < 5) rand_inputs(1'($urandom_range(0, 1))); else in_valid = 1'b0;
            end
        end
        chk("bp_accepted", 64'(n_acc), 64'd2);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_no_gap", 64'(out_valid), 64'd1);
            cycle();
            if (accepted) begin
                n_acc++;
                if (n_acc < 5) rand_inputs(1'($urandom_range(0, 1))); else in_valid = 1'b0;
            end
        end
        chk("bp_total", 64'(n_acc), 64'd5);
        chk("bp_drained", 64'(out_valid), 64'd0);

        // reset with both stages full
        out_ready = 1'b0;
        rand_inputs(1'b1);
        in_valid = 1'b1;
        cycle();
        rand_inputs(1'b0);
        cycle();
        in_valid = 1'b0;
        chk("rst_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        q.delete();
        cycle();
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        chk_b("rst_mid_outputs", get_out(), bundle_t'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("rst_no_stale", 64'(out_valid), 64'd0);

        // random mixed-op stream
        sent = 0; guard = 0; in_valid = 1'b0; accepted = 1'b0;
        while (sent < 1000 && guard < 20000) begin
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_inputs(1'($urandom_range(0, 1)));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (accepted) sent++;
            guard++;
        end
        chk("stream_count", 64'(sent), 64'd1000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            cycle();
            guard++;
        end
        chk("stream_drain", 64'(q.size()), 64'd0);
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
